// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity via UART_TX_PARITY_EN, STOP_BITS stop)
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  input  logic [DIV_W-1:0]     baud_div_in,
  output logic                 tx_busy_out,
  output logic                 tx_done_out,
  output logic                 tx_data_out
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_W-1:0]     period;
  logic [DIV_W-1:0]     cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif
  assign tx_ready_out = state == IDLE;
  assign tx_busy_out  = state != IDLE;
  // frame sequencer: every bit holds for period+1 cycles, line and done are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      period      <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      tx_data_out <= 1'b1;
      tx_done_out <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      tx_done_out <= 1'b0;
      case (state)
        IDLE: begin
          tx_data_out <= 1'b1;
          if (tx_valid_in) begin
            shreg       <= tx_data_in;
            period      <= baud_div_in;
            cnt         <= baud_div_in;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            tx_data_out <= 1'b0;
            state       <= START;
`ifdef UART_TX_PARITY_EN
            par         <= (^tx_data_in) ^ PARITY_ODD[0];
`endif
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt         <= period;
            tx_data_out <= shreg[0];
            state       <= DATA;
          end else cnt <= cnt - 1'b1;
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= period;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_data_out <= par;
              state       <= PARITY;
`else
              tx_data_out <= 1'b1;
              state       <= STOP;
`endif
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              shreg       <= shreg >> 1;
              tx_data_out <= shreg[1];
            end
          end else cnt <= cnt - 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            cnt         <= period;
            tx_data_out <= 1'b1;
            state       <= STOP;
          end else cnt <= cnt - 1'b1;
        end
`endif
        STOP: begin
          if (cnt == '0) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_done_out <= 1'b1;
              state       <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
              cnt      <= period;
            end
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized self-checking bench for uart_tx_param against a bit-list reference model
module tb_uart_tx_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  data = '0;
  logic [15:0] div = '0;
  logic        valid [3];
  logic        ready [3];
  logic        busy [3];
  logic        done [3];
  logic        line [3];
  int          tests = 0;
  int          fails = 0;
  int          db [3] = '{8, 8, 5};
  int          sb [3] = '{1, 2, 1};
  int          podd [3] = '{0, 1, 0};
`ifdef UART_TX_PARITY_EN
  int          par = 1;
`else
  int          par = 0;
`endif
  always #5 clk = ~clk;
  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (.clk(clk), .rst_n(rst_n), .tx_data_in(data[7:0]),
    .tx_valid_in(valid[0]), .tx_ready_out(ready[0]), .baud_div_in(div), .tx_busy_out(busy[0]), .tx_done_out(done[0]), .tx_data_out(line[0]));
  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u1 (.clk(clk), .rst_n(rst_n), .tx_data_in(data[7:0]),
    .tx_valid_in(valid[1]), .tx_ready_out(ready[1]), .baud_div_in(div), .tx_busy_out(busy[1]), .tx_done_out(done[1]), .tx_data_out(line[1]));
  uart_tx_param #(.DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u2 (.clk(clk), .rst_n(rst_n), .tx_data_in(data[4:0]),
    .tx_valid_in(valid[2]), .tx_ready_out(ready[2]), .baud_div_in(div), .tx_busy_out(busy[2]), .tx_done_out(done[2]), .tx_data_out(line[2]));
  // the idx-th bit of the frame: start, data LSB-first, optional parity, stop bits
  function automatic logic exp_bit(int d, logic [8:0] w, int idx);
    logic p;
    p = podd[d][0];
    for (int i = 0; i < db[d]; i++) p ^= w[i];
    if (idx == 0) return 1'b0;
    if (idx <= db[d]) return w[idx-1];
    if (par == 1 && idx == db[d] + 1) return p;
    return 1'b1;
  endfunction
  task automatic start(int d, logic [8:0] w, logic [15:0] dv);
    @(negedge clk);
    tests++;
    if (ready[d] !== 1'b1) begin fails++; $display("FAIL ready_before_start dut%0d got %b want 1", d, ready[d]); end
    data = w;
    div = dv;
    valid[d] = 1'b1;
  endtask
  // checks a frame cycle by cycle from the acceptance edge; valid stays high with junk mid-frame
  task automatic frame(int d, logic [8:0] w, logic [15:0] dv, bit nv, logic [8:0] nw, logic [15:0] ndv);
    int p, n;
    logic e;
    p = int'(dv) + 1;
    n = (1 + db[d] + par + sb[d]) * p;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) data = 9'($urandom);
      if (k == 3) div = 16'd1;
      e = exp_bit(d, w, (k - 1) / p);
      tests++;
      if (line[d] !== e) begin fails++; $display("FAIL line dut%0d w=%h div=%0d cyc %0d got %b want %b", d, w, dv, k, line[d], e); end
      tests++;
      if (busy[d] !== 1'b1 || ready[d] !== 1'b0 || done[d] !== 1'b0) begin
        fails++; $display("FAIL status dut%0d cyc %0d busy=%b ready=%b done=%b want 1 0 0", d, k, busy[d], ready[d], done[d]);
      end
    end
    @(negedge clk);
    tests++;
    if (done[d] !== 1'b1 || busy[d] !== 1'b0 || ready[d] !== 1'b1 || line[d] !== 1'b1) begin
      fails++; $display("FAIL done_cycle dut%0d done=%b busy=%b ready=%b line=%b want 1 0 1 1", d, done[d], busy[d], ready[d], line[d]);
    end
    valid[d] = nv;
    data = nw;
    div = ndv;
    if (!nv) begin
      @(negedge clk);
      tests++;
      if (done[d] !== 1'b0 || line[d] !== 1'b1) begin fails++; $display("FAIL done_width dut%0d done=%b line=%b want 0 1", d, done[d], line[d]); end
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (line[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0 || ready[d] !== 1'b1) begin
        fails++; $display("FAIL reset dut%0d line=%b busy=%b done=%b ready=%b want 1 0 0 1", d, line[d], busy[d], done[d], ready[d]);
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    start(0, 9'h0A5, 16'd3);
    frame(0, 9'h0A5, 16'd3, 1'b0, 9'h0, 16'd0);
    start(1, 9'h0A5, 16'd3);
    frame(1, 9'h0A5, 16'd3, 1'b0, 9'h0, 16'd0);
  endtask
  task automatic test_random();
    logic [8:0]  w;
    logic [15:0] dv;
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 3; d += 2) begin
        w = 9'($urandom);
        dv = 16'($urandom_range(0, 5));
        start(d, w, dv);
        frame(d, w, dv, 1'b0, 9'h0, 16'd0);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [8:0] w0, w1;
    start(1, 9'h000, 16'd0);
    frame(1, 9'h000, 16'd0, 1'b1, 9'h0FF, 16'd0);
    frame(1, 9'h0FF, 16'd0, 1'b0, 9'h0, 16'd0);
    w0 = 9'($urandom);
    w1 = 9'($urandom);
    start(0, w0, 16'd2);
    frame(0, w0, 16'd2, 1'b1, w1, 16'd1);
    frame(0, w1, 16'd1, 1'b0, 9'h0, 16'd0);
  endtask
  task automatic test_div_change();
    logic [8:0] w0, w1;
    w0 = 9'($urandom);
    w1 = 9'($urandom);
    start(0, w0, 16'd7);
    frame(0, w0, 16'd7, 1'b1, w1, 16'd1);
    frame(0, w1, 16'd1, 1'b0, 9'h0, 16'd0);
  endtask
  task automatic test_five_bits();
    start(2, 9'h01F, 16'd0);
    frame(2, 9'h01F, 16'd0, 1'b0, 9'h0, 16'd0);
    start(2, 9'h1EA, 16'd0);
    frame(2, 9'h1EA, 16'd0, 1'b0, 9'h0, 16'd0);
  endtask
  task automatic test_reset_mid();
    logic [8:0] w;
    start(0, 9'h0C3, 16'd1);
    @(posedge clk);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (line[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b1) begin
      fails++; $display("FAIL reset_mid line=%b busy=%b done=%b ready=%b want 1 0 0 1", line[0], busy[0], done[0], ready[0]);
    end
    valid[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (done[0] !== 1'b0 || line[0] !== 1'b1) begin fails++; $display("FAIL reset_hold done=%b line=%b want 0 1", done[0], line[0]); end
    rst_n = 1'b1;
    w = 9'($urandom);
    start(0, w, 16'd2);
    frame(0, w, 16'd2, 1'b0, 9'h0, 16'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_div_change();
    test_five_bits();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Serialises one word per frame: start bit, DATA_BITS data bits LSB-first, optional parity bit, then STOP_BITS stop bits.
- Bit period is set at run time by a divisor sampled at frame acceptance.
- Sits between a byte/word producer (valid/ready handshake) and the serial TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
DIV_W, 16, width of the baud divisor input.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data_in  input  DATA_BITS  word to transmit; sampled on acceptance
tx_valid_in  input  1  producer has a word on tx_data_in
tx_ready_out  output  1  block can accept a word this cycle
baud_div_in  input  DIV_W  bit period minus one, in clk cycles; sampled on acceptance
tx_busy_out  output  1  high while a frame is on the line
tx_done_out  output  1  one-cycle pulse after the last stop bit completes
tx_data_out  output  1  serial line, idle high, registered

Behaviour:
- Reset values (async, immediate): tx_data_out=1, tx_busy_out=0, tx_done_out=0, tx_ready_out=1, state=IDLE, all counters and shift register cleared.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- tx_ready_out = 1 only in IDLE (combinational from state).
- Acceptance = tx_valid_in && tx_ready_out at a rising edge.
  - On acceptance, latch tx_data_in into the shift register and baud_div_in into the period register, then go to START.
- Bit period P = latched divisor + 1 cycles. Divisor 0 means P = 1. Max P = 2^DIV_W.
- Every non-IDLE state holds its line value for exactly P cycles, timed by a down-counter reloaded on each bit boundary.
- Latency: tx_data_out drops to 0 on the first cycle after the acceptance edge.
- START: line 0 for P cycles.
- DATA: line = shift-register LSB. Shift right at each bit boundary. A bit counter runs DATA_BITS bits, then moves to PARITY (if compiled) or STOP.
- PARITY: line = XOR of the latched data word, XORed with PARITY_ODD, for P cycles.
- STOP: line 1 for STOP_BITS*P cycles, then IDLE.
- On the cycle IDLE is re-entered: tx_done_out=1 for that single cycle and tx_ready_out=1.
- tx_busy_out = 1 in every state except IDLE.
- Back-to-back frames:
  - A word can be accepted on the same cycle tx_done_out pulses.
  - The line is then high for STOP_BITS*P + 1 cycles between frames. No line glitch.
- Changes on tx_data_in or baud_div_in after acceptance do not affect the frame in flight. Deasserting tx_valid_in after acceptance has no effect.
- tx_valid_in high outside IDLE: ignored, not queued. The word is held by the producer per the valid/ready rules.
- Reset asserted mid-frame: line returns high immediately and the frame is aborted. No tx_done_out pulse. The block is ready again on the first clock after deassertion.
- Frame length in cycles = (1 + DATA_BITS + parity + STOP_BITS) * P.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists and one parity bit is inserted between the last data bit and the stop bit(s), with the sense set by PARITY_ODD.
- Undefined: no PARITY state or parity logic. DATA goes directly to STOP and PARITY_ODD has no effect.

Test Plan:
- Macro off, DATA_BITS=8, baud_div_in=3, send 0xA5 (acceptance at cycle 0) -> cycles 1-4 line 0; data bits 1,0,1,0,0,1,0,1 on cycles 5-36, 4 cycles each; stop 1 on cycles 37-40; tx_done_out=1 on cycle 41 only; tx_busy_out high on cycles 1-40.
- Macro on, PARITY_ODD=0, same stimulus -> parity 0 on cycles 37-40, stop on 41-44, done on 45. With PARITY_ODD=1 -> parity 1.
- Back-to-back: tx_valid_in held high with 0x00 then 0xFF, baud_div_in=0, STOP_BITS=2 -> second start bit begins exactly 3 cycles after the first frame's last data bit; both frames exact; one done pulse per frame.
- Divisor change mid-frame: accept with baud_div_in=7, set it to 1 on cycle 3 -> whole frame keeps 8-cycle bits; next frame uses 2-cycle bits.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx_data_out=1 and tx_busy_out=0 with no clock edge, no done pulse; after release, next frame is transmitted correctly.
- DATA_BITS=5, STOP_BITS=1, baud_div_in=0, send 0x1F (only 5 bits used) -> line 0,1,1,1,1,1,1 over 7 cycles, then done pulse.
